wave_capture_trig: RTL
======================

# wave_capture_trig

Zero-crossing-triggered waveform capture stage feeding the double-buffered sample RAM read by the waveform display. It watches the 16-bit signed audio sample stream and, after each rising zero crossing, writes 256 consecutive samples as 8-bit offset-binary values into the half of the RAM not being displayed. It swaps halves only while the display reports vertical blanking, so a frame never shows a half-written buffer.

## Interface
Parameters:
- AUTO_TIMEOUT, default 1024: consecutive non-trigger samples in ARMED before a forced trigger; range 2..65535; used only with WAVE_CAPTURE_AUTOTRIG_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- new_sample_ready  input  1  one-cycle strobe: new_sample_in valid this cycle.
- new_sample_in  input  16  signed two's-complement audio sample.
- wave_display_idle  input  1  level; high during display vertical blanking.
- write_address  output  9  RAM write address {write_index, count[7:0]}.
- write_enable  output  1  RAM write strobe, one cycle per captured sample.
- write_sample  output  8  offset-binary sample {~s[15], s[14:8]}.
- read_index  output  1  RAM half the display reads; write_index = ~read_index.

## Operation
- Sample conversion: s = new_sample_in; write_sample = {~s[15], s[14:8]}. -32768 maps to 0x00, 0 maps to 0x80, 32767 maps to 0xFF.
- prev_sample register (16 b) loads new_sample_in on every new_sample_ready strobe, in every state.
- Trigger condition on a strobe: prev_sample[15]==1 and new_sample_in[15]==0.
- States:
  - ARMED: on a trigger strobe, write the sample at count 0, set count=1, go to ACTIVE. Non-trigger strobes write nothing.
  - ACTIVE: each strobe writes at count, then count increments. The strobe that writes count 255 moves to WAIT; count wraps to 0.
  - WAIT: strobes are ignored for writing. The first cycle with wave_display_idle==1 toggles read_index and returns to ARMED. If idle is already high on entry, the toggle occurs on the next cycle.
- Exactly 256 writes per capture, to addresses {~read_index, 0x00}..{~read_index, 0xFF} in order.
- read_index toggles only from WAIT, at most once per capture.

## Timing
- Reset (async assert, sync-free release): state=ARMED, count=0, read_index=0, prev_sample=0, write_enable=0, write_address=0, write_sample=0, auto counter=0.
- prev_sample resets to 0, so the first post-reset sample cannot trigger.
- Outputs are registered. write_enable, write_address, and write_sample update in the cycle after the qualifying strobe. write_enable is high for exactly one cycle; address and sample hold until the next write.
- Back-to-back strobes on consecutive cycles are supported: one write per cycle, no drops.
- Idle and strobe in the same WAIT cycle: the strobe updates prev_sample only, read_index toggles, and the next state is ARMED. That strobe cannot trigger.
- Reset mid-ACTIVE: the capture is abandoned and read_index returns to 0. The partial buffer contents are don't-care.

## Configuration
- WAVE_CAPTURE_AUTOTRIG_EN defined:
  - A 16-bit counter counts non-trigger strobes in ARMED. It clears on entry to ARMED and on reset.
  - The AUTO_TIMEOUT-th consecutive non-trigger strobe is treated as a trigger: it is written at count 0 and the state moves to ACTIVE.
  - Result: DC or silent input still refreshes the display.
- Undefined: no counter. ARMED waits indefinitely for a real zero crossing, and AUTO_TIMEOUT is ignored.

## Test plan
- Reset: drive reset=0 mid-ACTIVE -> all outputs 0, read_index=0. After release, the first strobe with sample 0x0100 produces no write.
- Trigger: strobes -5 then +3 -> write at address 0x100 with data 0x80 one cycle later. The next 255 strobes write 0x101..0x1FF. Further strobes produce no writes.
- Conversion: in ACTIVE, inputs 0x8000, 0x7FFF, 0xFF00 -> write_sample 0x00, 0xFF, 0x7F.
- Buffer swap: complete a capture with wave_display_idle=0 -> read_index stays 0. Raise idle -> read_index=1 next cycle. The next capture writes 0x000..0x0FF.
- Back-to-back: 256 strobes on consecutive cycles after a trigger -> 256 single-cycle write_enable pulses with no gaps or duplicate addresses.
- Autotrigger (macro on, AUTO_TIMEOUT=4): constant +100 input -> the 4th strobe is written at count 0. With the macro off, the same input produces no writes for 10000 strobes.

Source files
------------

// File: rtl/wave_capture_trig_if.sv
// Sample-stream / capture-RAM port bundle for wave_capture_trig.
// master = capture block (drives the RAM write port), slave = surrounding system.
interface wave_capture_trig_if;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  modport master (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );

  modport slave (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture_trig.sv
// Zero-crossing triggered 256-sample capture into the non-displayed RAM half.
// Optional forced trigger on quiet input: define WAVE_CAPTURE_AUTOTRIG_EN.
module wave_capture_trig #(
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  wave_capture_trig_if.master bus
);
  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        read_index_q, read_index_d;
  logic [15:0] prev_sample_q, prev_sample_d;
  logic        write_enable_q, write_enable_d;
  logic [8:0]  write_address_q, write_address_d;
  logic [7:0]  write_sample_q, write_sample_d;
  logic        strobe, trig;

  assign strobe = bus.new_sample_ready;

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  logic [15:0] auto_cnt_q, auto_cnt_d;
  logic        auto_fire;
  // The AUTO_TIMEOUT-th consecutive non-trigger strobe counts as a trigger.
  assign auto_fire = (auto_cnt_q == 16'(AUTO_TIMEOUT - 1));
`else
  logic unused_auto_timeout;
  assign unused_auto_timeout = ^32'(AUTO_TIMEOUT);
`endif

  // Rising zero crossing: previous sample negative, current non-negative.
  assign trig = strobe && prev_sample_q[15] && !bus.new_sample_in[15];

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    read_index_d    = read_index_q;
    prev_sample_d   = strobe ? bus.new_sample_in : prev_sample_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    auto_cnt_d      = 16'd0;
`endif
    unique case (state_q)
      ARMED: begin
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        auto_cnt_d = auto_cnt_q;
        if (strobe && !trig) auto_cnt_d = auto_cnt_q + 16'd1;
        if (trig || (strobe && auto_fire)) begin
`else
        if (trig) begin
`endif
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, 8'h00};
          write_sample_d  = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
          count_d         = 8'd1;
          state_d         = ACTIVE;
        end
      end
      ACTIVE: begin
        if (strobe) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_sample_d  = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
          count_d         = count_q + 8'd1;
          if (count_q == 8'hFF) state_d = WAIT;
        end
      end
      WAIT: begin
        // Swap only in blanking so a frame never shows a half-written buffer.
        if (bus.wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ARMED;
      count_q         <= 8'd0;
      read_index_q    <= 1'b0;
      prev_sample_q   <= 16'd0;
      write_enable_q  <= 1'b0;
      write_address_q <= 9'd0;
      write_sample_q  <= 8'd0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
      auto_cnt_q      <= 16'd0;
`endif
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      read_index_q    <= read_index_d;
      prev_sample_q   <= prev_sample_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
      auto_cnt_q      <= auto_cnt_d;
`endif
    end
  end

  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_sample  = write_sample_q;
  assign bus.read_index    = read_index_q;
endmodule
